// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: ALU and long-latency result ports, scoreboard checks, register file write port.
interface wb_arbiter_if;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_stall_o;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_data_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  chk1_reg_i;
  logic [4:0]  chk2_reg_i;
  logic        chk1_busy_o;
  logic        chk2_busy_o;
  logic        wr_en_o;
  logic [4:0]  wr_reg_o;
  logic [31:0] wr_data_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  mem_valid_i, mem_rd_i, mem_data_i,
    input  issue_i, issue_rd_i, chk1_reg_i, chk2_reg_i,
    output alu_stall_o, mem_ready_o, chk1_busy_o, chk2_busy_o,
    output wr_en_o, wr_reg_o, wr_data_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output mem_valid_i, mem_rd_i, mem_data_i,
    output issue_i, issue_rd_i, chk1_reg_i, chk2_reg_i,
    input  alu_stall_o, mem_ready_o, chk1_busy_o, chk2_busy_o,
    input  wr_en_o, wr_reg_o, wr_data_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered long-latency results onto the
// single register file write port, and tracks per-register pending bits for decode.
module wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic [NR-1:0] pend_q, pend_d;
  logic          wr_en_q, wr_en_d;
  logic [RW-1:0] wr_reg_q, wr_reg_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          mem_ready;
  logic          push;
  logic          pop;
  logic          empty;
  entry_t        head;

  assign mem_ready = rst_ni && (cnt_q < CW'(DEPTH));

  // Arbitration, FIFO bookkeeping and scoreboard update for the coming edge.
  always_comb begin
    head      = fifo_q[rptr_q];
    empty     = (cnt_q == '0);
    push      = bus.mem_valid_i && mem_ready && (bus.mem_rd_i != '0);
    pop       = 1'b0;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    fifo_d    = fifo_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    pend_d    = pend_q;

    // A full FIFO forces a drain; an ALU result to x0 still blocks the pop.
    if (stall_q && !empty) begin
      pop = 1'b1;
    end else if (bus.alu_valid_i) begin
      if (bus.alu_rd_i != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = bus.alu_rd_i;
        wr_data_d = bus.alu_data_i;
      end
    end else if (!empty) begin
      pop = 1'b1;
    end

    if (pop) begin
      wr_en_d           = 1'b1;
      wr_reg_d          = head.rd;
      wr_data_d         = head.data;
      rptr_d            = rptr_q + PW'(1);
      pend_d[head.rd]   = 1'b0;
    end

    if (push) begin
      fifo_d[wptr_q] = '{rd: bus.mem_rd_i, data: bus.mem_data_i};
      wptr_d         = wptr_q + PW'(1);
    end

    // Issue is applied after the pop clear so a same-edge set wins.
    if (bus.issue_i && (bus.issue_rd_i != '0)) begin
      pend_d[bus.issue_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;

    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    stall_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      pend_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign bus.mem_ready_o = mem_ready;
  assign bus.alu_stall_o = stall_q;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_reg_o    = wr_reg_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.chk1_busy_o = (bus.chk1_reg_i != '0) && pend_q[bus.chk1_reg_i];
  assign bus.chk2_busy_o = (bus.chk2_reg_i != '0) && pend_q[bus.chk2_reg_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic clk;
  logic rst_ni;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] m_pend;
  bit          m_stall;
  bit          m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  bit chk_on;
  int n_pass;
  int n_total;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: FIFO as a queue, scoreboard as a bit vector, priority rules applied directly.
  always @(posedge clk) begin : model
    ent_t e;
    bit   rdy;
    if (!rst_ni) begin
      mq.delete();
      m_pend  = '0;
      m_stall = 1'b0;
      m_en    = 1'b0;
      m_reg   = '0;
      m_data  = '0;
    end else begin
      assert (!(bus.issue_i && bus.issue_rd_i != 5'd0 && m_pend[bus.issue_rd_i]))
        else $error("protocol violation: issue to pending register x%0d", bus.issue_rd_i);
      rdy  = mq.size() < DEPTH;
      m_en = 1'b0;
      if ((m_stall && mq.size() > 0) || (!bus.alu_valid_i && mq.size() > 0)) begin
        e      = mq.pop_front();
        m_en   = 1'b1;
        m_reg  = e.rd;
        m_data = e.data;
        m_pend[e.rd] = 1'b0;
      end else if (bus.alu_valid_i && bus.alu_rd_i != 5'd0) begin
        m_en   = 1'b1;
        m_reg  = bus.alu_rd_i;
        m_data = bus.alu_data_i;
      end
      if (bus.issue_i && bus.issue_rd_i != 5'd0) m_pend[bus.issue_rd_i] = 1'b1;
      m_pend[0] = 1'b0;
      if (bus.mem_valid_i && rdy && bus.mem_rd_i != 5'd0) begin
        e.rd   = bus.mem_rd_i;
        e.data = bus.mem_data_i;
        mq.push_back(e);
      end
      m_stall = (mq.size() == DEPTH);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("wr_en",     32'(bus.wr_en_o),     32'(m_en));
      check("wr_reg",    32'(bus.wr_reg_o),    32'(m_reg));
      check("wr_data",   bus.wr_data_o,        m_data);
      check("alu_stall", 32'(bus.alu_stall_o), 32'(m_stall));
      check("mem_ready", 32'(bus.mem_ready_o), 32'(rst_ni && (mq.size() < DEPTH)));
      check("chk1_busy", 32'(bus.chk1_busy_o), 32'(bus.chk1_reg_i != 5'd0 && m_pend[bus.chk1_reg_i]));
      check("chk2_busy", 32'(bus.chk2_busy_o), 32'(bus.chk2_reg_i != 5'd0 && m_pend[bus.chk2_reg_i]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.mem_valid_i = 1'b0; bus.mem_rd_i = '0; bus.mem_data_i = '0;
    bus.issue_i     = 1'b0; bus.issue_rd_i = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = rd; bus.alu_data_i = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    bus.mem_valid_i = 1'b1; bus.mem_rd_i = rd; bus.mem_data_i = d;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    chk_on = 1'b0;
    idle();
    bus.chk1_reg_i = '0;
    bus.chk2_reg_i = '0;
    rst_ni = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc();
    check("rst wr_en", 32'(bus.wr_en_o), 32'd0);
    check("rst wr_reg", 32'(bus.wr_reg_o), 32'd0);
    check("rst mem_ready low", 32'(bus.mem_ready_o), 32'd0);

    // ALU result latency
    rst_ni = 1'b1;
    alu(5'd5, 32'hDEADBEEF);
    cyc();
    idle();
    check("alu wr_en", 32'(bus.wr_en_o), 32'd1);
    check("alu wr_reg", 32'(bus.wr_reg_o), 32'd5);
    check("alu wr_data", bus.wr_data_o, 32'hDEADBEEF);
    cyc();
    check("alu wr_en off", 32'(bus.wr_en_o), 32'd0);
    check("mem_ready idle", 32'(bus.mem_ready_o), 32'd1);

    // Issue, then long-latency result three cycles later
    bus.issue_i = 1'b1; bus.issue_rd_i = 5'd7; bus.chk1_reg_i = 5'd7;
    cyc();
    bus.issue_i = 1'b0;
    check("busy after issue", 32'(bus.chk1_busy_o), 32'd1);
    cyc();
    cyc();
    mem(5'd7, 32'h12345678);
    cyc();
    idle();
    check("busy while queued", 32'(bus.chk1_busy_o), 32'd1);
    check("no write on accept", 32'(bus.wr_en_o), 32'd0);
    cyc();
    check("mem wr_en", 32'(bus.wr_en_o), 32'd1);
    check("mem wr_reg", 32'(bus.wr_reg_o), 32'd7);
    check("mem wr_data", bus.wr_data_o, 32'h12345678);
    check("busy cleared at pop", 32'(bus.chk1_busy_o), 32'd0);

    // ALU and mem at the same edge
    alu(5'd3, 32'hA5A50003);
    mem(5'd4, 32'h00000404);
    cyc();
    idle();
    check("same-edge alu first", 32'(bus.wr_reg_o), 32'd3);
    cyc();
    check("same-edge mem next", 32'(bus.wr_reg_o), 32'd4);
    check("same-edge mem data", bus.wr_data_o, 32'h00000404);
    cyc();
    check("same-edge idle", 32'(bus.wr_en_o), 32'd0);

    // Continuous ALU stream forces a drain through alu_stall_o
    alu(5'd1, 32'h000000A1); mem(5'd10, 32'h0000100A);
    cyc();
    check("stream wr_reg 1", 32'(bus.wr_reg_o), 32'd1);
    check("stream ready 1", 32'(bus.mem_ready_o), 32'd1);
    alu(5'd2, 32'h000000A2); mem(5'd11, 32'h0000100B);
    cyc();
    check("stream wr_reg 2", 32'(bus.wr_reg_o), 32'd2);
    check("full ready", 32'(bus.mem_ready_o), 32'd0);
    check("full stall", 32'(bus.alu_stall_o), 32'd1);
    bus.mem_valid_i = 1'b0;
    alu(5'd3, 32'h000000A3);
    cyc();
    check("drain wr_reg", 32'(bus.wr_reg_o), 32'd10);
    check("drain wr_data", bus.wr_data_o, 32'h0000100A);
    check("drain stall off", 32'(bus.alu_stall_o), 32'd0);
    check("drain ready", 32'(bus.mem_ready_o), 32'd1);
    alu(5'd4, 32'h000000A4);
    cyc();
    check("stream wr_reg 4", 32'(bus.wr_reg_o), 32'd4);
    idle();
    cyc();
    check("second drain", 32'(bus.wr_reg_o), 32'd11);
    cyc();
    check("stream done", 32'(bus.wr_en_o), 32'd0);

    // rd=0 corner cases
    alu(5'd0, 32'hFFFFFFFF);
    cyc();
    idle();
    check("alu x0 no write", 32'(bus.wr_en_o), 32'd0);
    check("alu x0 hold reg", 32'(bus.wr_reg_o), 32'd11);
    mem(5'd0, 32'h0BADF00D);
    check("mem x0 ready", 32'(bus.mem_ready_o), 32'd1);
    cyc();
    idle();
    cyc();
    check("mem x0 never written", 32'(bus.wr_en_o), 32'd0);
    mem(5'd9, 32'h00000909);
    cyc();
    idle();
    alu(5'd0, 32'h0);
    cyc();
    idle();
    check("alu x0 blocks pop", 32'(bus.wr_en_o), 32'd0);
    cyc();
    check("pop after x0", 32'(bus.wr_reg_o), 32'd9);
    bus.issue_i = 1'b1; bus.issue_rd_i = 5'd0; bus.chk1_reg_i = 5'd0;
    cyc();
    idle();
    check("issue x0 not busy", 32'(bus.chk1_busy_o), 32'd0);

    // Reset with a full FIFO and two pending bits
    bus.issue_i = 1'b1; bus.issue_rd_i = 5'd20; bus.chk1_reg_i = 5'd20; bus.chk2_reg_i = 5'd21;
    cyc();
    bus.issue_rd_i = 5'd21;
    cyc();
    idle();
    alu(5'd1, 32'h1); mem(5'd22, 32'h22);
    cyc();
    alu(5'd2, 32'h2); mem(5'd23, 32'h23);
    cyc();
    idle();
    check("pre-reset busy1", 32'(bus.chk1_busy_o), 32'd1);
    check("pre-reset busy2", 32'(bus.chk2_busy_o), 32'd1);
    check("pre-reset full", 32'(bus.mem_ready_o), 32'd0);
    rst_ni = 1'b0;
    cyc();
    check("post-reset wr_en", 32'(bus.wr_en_o), 32'd0);
    check("post-reset busy1", 32'(bus.chk1_busy_o), 32'd0);
    check("post-reset busy2", 32'(bus.chk2_busy_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    check("post-reset ready", 32'(bus.mem_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("no stale write", 32'(bus.wr_en_o), 32'd0);
    end

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 4000; n++) begin
      int r;
      rst_ni = ($urandom_range(0, 299) != 0);
      bus.alu_valid_i = ($urandom_range(0, 99) < 45);
      bus.alu_rd_i    = 5'($urandom_range(0, 31));
      bus.alu_data_i  = $urandom;
      bus.mem_valid_i = ($urandom_range(0, 99) < 50);
      bus.mem_data_i  = $urandom;
      bus.mem_rd_i    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 31);
        for (int k = 0; k < 31; k++) begin
          if (m_pend[1 + ((r - 1 + k) % 31)]) begin
            bus.mem_rd_i = 5'(1 + ((r - 1 + k) % 31));
            break;
          end
        end
      end
      r = $urandom_range(0, 31);
      bus.issue_rd_i = 5'(r);
      bus.issue_i    = ($urandom_range(0, 5) == 0) && (r == 0 || !m_pend[r]);
      bus.chk1_reg_i = 5'($urandom_range(0, 31));
      bus.chk2_reg_i = 5'($urandom_range(0, 31));
      cyc();
    end

    rst_ni = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) cyc();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
